// File: rtl/dmem_obi_slave.sv
// Word-addressed data memory on the req/gnt/rvalid bus, one transaction in flight,
// with programmable grant and response latencies.
module dmem_obi_slave #(
    parameter logic [31:0] BASE_ADDR      = 32'h00002800,
    parameter int unsigned DEPTH_WORDS    = 2048,
    parameter int unsigned GNT_LATENCY    = 0,
    parameter int unsigned RVALID_LATENCY = 1,
    parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        busy_o
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned GW = (GNT_LATENCY > 0) ? $clog2(GNT_LATENCY + 1) : 1;
    localparam int unsigned RW = $clog2(RVALID_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GNT_WAIT  = 2'd1,
        RESP_WAIT = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [GW-1:0]   gnt_cnt, gnt_cnt_n;
    logic [RW-1:0]   rsp_cnt, rsp_cnt_n;
    logic [31:0]     rdata_q;
    logic            err_q;
    logic            take;
    logic            rvalid;
    logic            in_range;
    logic [31:0]     offset;
    logic [AW-1:0]   idx;
    logic [31:0]     mem [DEPTH_WORDS];

    // 33-bit upper bound so a base near the top of the address space cannot wrap
    assign in_range = (data_addr_i >= BASE_ADDR) &&
                      ({1'b0, data_addr_i} < ({1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS)));
    assign offset   = data_addr_i - BASE_ADDR;
    assign idx      = AW'(offset >> 2);

    assign data_gnt_o = data_req_i && (state != RESP_WAIT) && (gnt_cnt == GW'(GNT_LATENCY));
    assign take       = data_gnt_o;
    assign rvalid     = (state == RESP_WAIT) && (rsp_cnt == RW'(RVALID_LATENCY));

    always_comb begin
        state_n   = state;
        gnt_cnt_n = gnt_cnt;
        rsp_cnt_n = rsp_cnt;
        case (state)
            IDLE, GNT_WAIT: begin
                if (take) begin
                    state_n   = RESP_WAIT;
                    gnt_cnt_n = '0;
                    rsp_cnt_n = RW'(1);
                end else if (data_req_i) begin
                    state_n   = GNT_WAIT;
                    gnt_cnt_n = gnt_cnt + GW'(1);
                end else begin
                    state_n   = IDLE;
                    gnt_cnt_n = '0;
                end
            end
            RESP_WAIT: begin
                if (rvalid) begin
                    state_n   = IDLE;
                    rsp_cnt_n = '0;
                end else begin
                    rsp_cnt_n = rsp_cnt + RW'(1);
                end
            end
            default: begin
                state_n   = IDLE;
                gnt_cnt_n = '0;
                rsp_cnt_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            gnt_cnt <= '0;
            rsp_cnt <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            gnt_cnt <= gnt_cnt_n;
            rsp_cnt <= rsp_cnt_n;
            if (take) begin
                err_q <= !in_range;
                if (data_we_i)
                    rdata_q <= '0;
                else if (in_range)
                    rdata_q <= mem[idx];
                else
                    rdata_q <= ERR_RDATA;
            end
        end
    end

    // Array is deliberately outside the reset domain so granted stores survive a reset
    always_ff @(posedge clk) begin
        if (take && data_we_i && in_range) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (data_be_i[k])
                    mem[idx][8*k +: 8] <= data_wdata_i[8*k +: 8];
            end
        end
    end

    assign data_rvalid_o = rvalid;
    assign data_rdata_o  = rvalid ? rdata_q : '0;
    assign data_err_o    = rvalid ? err_q : 1'b0;
    assign busy_o        = (state == RESP_WAIT);

endmodule

// File: tb/tb_dmem_obi_slave.sv
// Directed bench: three instances cover (gnt 0, rvalid 1), (gnt 2, rvalid 1), (gnt 0, rvalid 3).
module tb_dmem_obi_slave;

    logic        clk;
    logic        reset_n;
    logic [2:0]  req;
    logic [31:0] addr  [3];
    logic [2:0]  we;
    logic [3:0]  be    [3];
    logic [31:0] wdata [3];
    logic [2:0]  gnt;
    logic [2:0]  rvalid;
    logic [31:0] rdata [3];
    logic [2:0]  err;
    logic [2:0]  busy;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dmem_obi_slave #(.GNT_LATENCY(0), .RVALID_LATENCY(1)) u0 (
        .clk(clk), .reset_n(reset_n), .data_req_i(req[0]), .data_addr_i(addr[0]),
        .data_we_i(we[0]), .data_be_i(be[0]), .data_wdata_i(wdata[0]),
        .data_gnt_o(gnt[0]), .data_rvalid_o(rvalid[0]), .data_rdata_o(rdata[0]),
        .data_err_o(err[0]), .busy_o(busy[0]));

    dmem_obi_slave #(.GNT_LATENCY(2), .RVALID_LATENCY(1)) u1 (
        .clk(clk), .reset_n(reset_n), .data_req_i(req[1]), .data_addr_i(addr[1]),
        .data_we_i(we[1]), .data_be_i(be[1]), .data_wdata_i(wdata[1]),
        .data_gnt_o(gnt[1]), .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1]),
        .data_err_o(err[1]), .busy_o(busy[1]));

    dmem_obi_slave #(.GNT_LATENCY(0), .RVALID_LATENCY(3)) u2 (
        .clk(clk), .reset_n(reset_n), .data_req_i(req[2]), .data_addr_i(addr[2]),
        .data_we_i(we[2]), .data_be_i(be[2]), .data_wdata_i(wdata[2]),
        .data_gnt_o(gnt[2]), .data_rvalid_o(rvalid[2]), .data_rdata_o(rdata[2]),
        .data_err_o(err[2]), .busy_o(busy[2]));

    // Drives one transaction on instance k; reports req cycles up to gnt and cycles from gnt to rvalid.
    task automatic access(input int k, input logic w, input logic [31:0] a, input logic [3:0] b,
                          input logic [31:0] d, output int gcyc, output int rcyc,
                          output logic [31:0] rd, output logic e, output bit timeout);
        gcyc = 0; rcyc = 0; rd = '0; e = 1'b0; timeout = 1'b0;
        @(negedge clk);
        req[k] = 1'b1; addr[k] = a; we[k] = w; be[k] = b; wdata[k] = d;
        for (int i = 0; i < 20; i++) begin
            #1;
            gcyc++;
            if (gnt[k]) break;
            @(negedge clk);
        end
        if (!gnt[k]) begin
            timeout = 1'b1;
            req[k] = 1'b0;
            return;
        end
        @(negedge clk);
        req[k] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            rcyc++;
            if (rvalid[k]) begin
                rd = rdata[k];
                e = err[k];
                return;
            end
            @(negedge clk);
        end
        timeout = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        #1;
        checks++;
        if ({gnt, rvalid, err, busy} !== 12'h000 || rdata[0] !== 32'h0 || rdata[1] !== 32'h0 ||
            rdata[2] !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b rvalid=%b err=%b busy=%b expected all 0",
                     gnt, rvalid, err, busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_basic_rw;
        int g, r; logic [31:0] rd; logic e; bit to;
        access(0, 1'b1, 32'h2800, 4'b1111, 32'h11223344, g, r, rd, e, to);
        checks++;
        if (to || g !== 1 || r !== 1 || e !== 1'b0 || rd !== 32'h0) begin
            errors++;
            $display("FAIL sw_basic: to=%0d gcyc=%0d rcyc=%0d err=%b rdata=%h expected 0 1 1 0 0",
                     to, g, r, e, rd);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rvalid[0] !== 1'b0 || rdata[0] !== 32'h0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_rvalid: rvalid=%b rdata=%h busy=%b expected 0 0 0",
                     rvalid[0], rdata[0], busy[0]);
        end
        access(0, 1'b0, 32'h2800, 4'b0000, 32'h0, g, r, rd, e, to);
        checks++;
        if (to || r !== 1 || e !== 1'b0 || rd !== 32'h11223344) begin
            errors++;
            $display("FAIL lw_basic: to=%0d rcyc=%0d err=%b rdata=%h expected 0 1 0 11223344",
                     to, r, e, rd);
        end
    endtask

    task automatic test_byte_lanes;
        int g, r; logic [31:0] rd; logic e; bit to;
        access(0, 1'b1, 32'h2804, 4'b1111, 32'hFFFFFFFF, g, r, rd, e, to);
        access(0, 1'b1, 32'h2805, 4'b0010, 32'h0000AB00, g, r, rd, e, to);
        access(0, 1'b0, 32'h2804, 4'b0001, 32'h0, g, r, rd, e, to);
        checks++;
        if (to || rd !== 32'hFFFFABFF) begin
            errors++;
            $display("FAIL sb_lane1: rdata=%h expected FFFFABFF", rd);
        end
        access(0, 1'b1, 32'h2806, 4'b1100, 32'h12340000, g, r, rd, e, to);
        access(0, 1'b0, 32'h2804, 4'b0000, 32'h0, g, r, rd, e, to);
        checks++;
        if (to || rd !== 32'h1234ABFF) begin
            errors++;
            $display("FAIL sh_upper: rdata=%h expected 1234ABFF", rd);
        end
        access(0, 1'b1, 32'h2804, 4'b0000, 32'h00000000, g, r, rd, e, to);
        access(0, 1'b0, 32'h2804, 4'b0000, 32'h0, g, r, rd, e, to);
        checks++;
        if (to || rd !== 32'h1234ABFF || e !== 1'b0) begin
            errors++;
            $display("FAIL be_zero_noop: rdata=%h err=%b expected 1234ABFF 0", rd, e);
        end
    endtask

    task automatic test_gnt_latency;
        int g, r; logic [31:0] rd; logic e; bit to;
        access(1, 1'b0, 32'h2800, 4'b1111, 32'h0, g, r, rd, e, to);
        checks++;
        if (to || g !== 3 || r !== 1) begin
            errors++;
            $display("FAIL gnt_lat_held: to=%0d gcyc=%0d rcyc=%0d expected 0 3 1", to, g, r);
        end
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h2800;
        #1;
        checks++;
        if (gnt[1] !== 1'b0) begin
            errors++;
            $display("FAIL gnt_lat_early: gnt=%b expected 0", gnt[1]);
        end
        @(negedge clk);
        req[1] = 1'b0;
        #1;
        checks++;
        if (gnt[1] !== 1'b0 || busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL gnt_lat_drop: gnt=%b busy=%b expected 0 0", gnt[1], busy[1]);
        end
        @(negedge clk);
        access(1, 1'b0, 32'h2800, 4'b1111, 32'h0, g, r, rd, e, to);
        checks++;
        if (to || g !== 3) begin
            errors++;
            $display("FAIL gnt_lat_restart: to=%0d gcyc=%0d expected 0 3", to, g);
        end
    endtask

    task automatic test_out_of_range;
        int g, r; logic [31:0] rd; logic e; bit to;
        access(0, 1'b0, 32'h2600, 4'b1111, 32'h0, g, r, rd, e, to);
        checks++;
        if (to || r !== 1 || e !== 1'b1 || rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL oor_read_low: to=%0d rcyc=%0d err=%b rdata=%h expected 0 1 1 DEADBEEF",
                     to, r, e, rd);
        end
        access(0, 1'b1, 32'h4800, 4'b1111, 32'h55555555, g, r, rd, e, to);
        checks++;
        if (to || e !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL oor_write_high: to=%0d err=%b rdata=%h expected 0 1 0", to, e, rd);
        end
        access(0, 1'b0, 32'h2800, 4'b1111, 32'h0, g, r, rd, e, to);
        checks++;
        if (to || e !== 1'b0 || rd !== 32'h11223344) begin
            errors++;
            $display("FAIL oor_no_alias: err=%b rdata=%h expected 0 11223344", e, rd);
        end
        access(0, 1'b1, 32'h47FC, 4'b1111, 32'hA5A5C3C3, g, r, rd, e, to);
        access(0, 1'b0, 32'h47FC, 4'b1111, 32'h0, g, r, rd, e, to);
        checks++;
        if (to || e !== 1'b0 || rd !== 32'hA5A5C3C3) begin
            errors++;
            $display("FAIL last_word: err=%b rdata=%h expected 0 A5A5C3C3", e, rd);
        end
    endtask

    task automatic test_back_to_back;
        int g, r; logic [31:0] rd; logic e; bit to;
        logic [4:0] gseen, vseen, bseen;
        logic [31:0] rd_at_valid;
        access(2, 1'b1, 32'h2808, 4'b1111, 32'hCAFEF00D, g, r, rd, e, to);
        checks++;
        if (to || g !== 1 || r !== 3) begin
            errors++;
            $display("FAIL rv_lat3: to=%0d gcyc=%0d rcyc=%0d expected 0 1 3", to, g, r);
        end
        rd_at_valid = '0;
        @(negedge clk);
        req[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h2808; be[2] = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            #1;
            gseen[i] = gnt[2];
            vseen[i] = rvalid[2];
            bseen[i] = busy[2];
            if (rvalid[2]) rd_at_valid = rdata[2];
            @(negedge clk);
        end
        req[2] = 1'b0;
        checks++;
        if (gseen !== 5'b10001 || vseen !== 5'b01000 || bseen !== 5'b01110) begin
            errors++;
            $display("FAIL held_req_seq: gnt=%b rvalid=%b busy=%b expected 10001 01000 01110",
                     gseen, vseen, bseen);
        end
        checks++;
        if (rd_at_valid !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL held_req_rdata: rdata=%h expected CAFEF00D", rd_at_valid);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_op;
        int g, r; logic [31:0] rd; logic e; bit to;
        int late_rv;
        @(negedge clk);
        req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h280C; be[2] = 4'b1111; wdata[2] = 32'h5A5A5A5A;
        #1;
        checks++;
        if (gnt[2] !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_gnt: gnt=%b expected 1", gnt[2]);
        end
        @(negedge clk);
        req[2] = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++;
        if (gnt[2] !== 1'b0 || rvalid[2] !== 1'b0 || busy[2] !== 1'b0 || err[2] !== 1'b0 ||
            rdata[2] !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs: gnt=%b rvalid=%b busy=%b err=%b rdata=%h expected 0",
                     gnt[2], rvalid[2], busy[2], err[2], rdata[2]);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        late_rv = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (rvalid[2] || busy[2]) late_rv++;
            @(negedge clk);
        end
        checks++;
        if (late_rv !== 0) begin
            errors++;
            $display("FAIL rst_no_late_rvalid: cycles_with_rvalid_or_busy=%0d expected 0", late_rv);
        end
        access(2, 1'b0, 32'h280C, 4'b1111, 32'h0, g, r, rd, e, to);
        checks++;
        if (to || r !== 3 || e !== 1'b0 || rd !== 32'h5A5A5A5A) begin
            errors++;
            $display("FAIL rst_write_kept: to=%0d rcyc=%0d err=%b rdata=%h expected 0 3 0 5A5A5A5A",
                     to, r, e, rd);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        req = '0;
        we = '0;
        for (int i = 0; i < 3; i++) begin
            addr[i] = '0; be[i] = '0; wdata[i] = '0;
        end
        test_reset();
        test_basic_rw();
        test_byte_lanes();
        test_gnt_latency();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
